seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier, the multi-cycle successor to the team's single-cycle 4x4 combinational product. It accepts two WIDTH-bit operands on a start pulse and returns a 2*WIDTH-bit product after WIDTH cycles. It supports unsigned and two's-complement signed operands, selected per operation. It sits between operand registers and the result/display path wherever a full-array multiplier is too large.

---
 rtl/mul_pkg.sv | 15 +
 rtl/mul_shift_add_dp.sv | 48 ++++
 rtl/seq_multiplier.sv | 91 +++++++++
 tb/tb_seq_multiplier.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and iteration-counter sizing.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Counter must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, left-shifting multiplicand, right-shifting
// multiplier and iteration counter, sequenced by load/step from the FSM.
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 last
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;

    // Value the accumulator takes on this step; also the final sum on the last step.
    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    assign last     = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, mcand_in};
            mplier_reg <= mplier_in;
            cnt_reg    <= '0;
        end else if (step) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, unsigned or two's complement per operation.
// Works on magnitudes and negates the final sum when operand signs differ.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state_reg;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               last;
    logic               neg_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;

    // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign mag1 = (signed_mode && operand1[WIDTH-1]) ? -operand1 : operand1;
    assign mag2 = (signed_mode && operand2[WIDTH-1]) ? -operand2 : operand2;

    mul_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .mcand_in (mag1),
        .mplier_in(mag2),
        .acc_next (acc_next),
        .last     (last)
    );

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            neg_reg     <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= step && last;
            if (load) begin
                neg_reg <= signed_mode & (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
            end
            if (step && last) begin
                product_reg <= neg_reg ? -acc_next : acc_next;
            end
        end
    end

    assign busy    = (state_reg == CALC);
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks on a 4-bit multiplier plus a randomised sweep on an 8-bit one.
module tb_seq_multiplier;

    logic       clk;
    logic       rst;
    logic       start4, sm4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [7:0] prod4;

    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    int total;
    int bad;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .operand1(a4), .operand2(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .operand1(a8), .operand2(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done on the 4-bit DUT; returns cycles elapsed since the start edge.
    task automatic wait_done4(output int cycles);
        cycles = 0;
        while (!done4 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run4(input string tag, input logic sm, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp);
        int cyc;
        sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(cyc);
        check({tag, " lat"}, cyc, 4);
        check({tag, " prod"}, prod4, exp);
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        logic stable;
        logic seen_done;
        int sa, sb;
        logic [15:0] exp16;

        total = 0; bad = 0;
        rst = 1'b1;
        start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset prod", prod4, 0);

        // 15*15 unsigned, with busy-width measurement
        sm4 = 0; a4 = 4'hF; b4 = 4'hF; start4 = 1;
        tick();
        start4 = 0;
        busy_cnt = 0; cyc = 0;
        while (!done4 && cyc < 20) begin
            if (busy4) busy_cnt++;
            tick();
            cyc++;
        end
        check("15x15 lat", cyc, 4);
        check("15x15 busy cycles", busy_cnt, 4);
        check("15x15 busy at done", busy4, 0);
        check("15x15 prod", prod4, 8'hE1);
        tick();
        check("done one pulse", done4, 0);

        run4("s -8*-8", 1, 4'h8, 4'h8, 8'h40);
        run4("s -3*5", 1, 4'hD, 4'h5, 8'hF1);
        run4("u 8*8", 0, 4'h8, 4'h8, 8'h40);
        run4("u 15*1", 0, 4'hF, 4'h1, 8'h0F);
        run4("s -1*1", 1, 4'hF, 4'h1, 8'hFF);

        // Back-to-back: start held through the done cycle
        sm4 = 0; a4 = 4'h5; b4 = 4'h5; start4 = 1;
        tick();
        wait_done4(cyc);
        check("b2b first lat", cyc, 4);
        check("b2b first prod", prod4, 8'h19);
        a4 = 4'h3; b4 = 4'h4;
        tick();
        start4 = 0;
        stable = 1'b1; cyc = 0;
        while (!done4 && cyc < 20) begin
            if (prod4 !== 8'h19) stable = 1'b0;
            tick();
            cyc++;
        end
        check("b2b held prod", stable, 1);
        check("b2b second lat", cyc, 4);
        check("b2b second prod", prod4, 8'h0C);

        // start while busy is ignored
        sm4 = 0; a4 = 4'h5; b4 = 4'h3; start4 = 1;
        tick();
        start4 = 0;
        tick();
        a4 = 4'h9; b4 = 4'h9; sm4 = 1; start4 = 1;
        tick();
        start4 = 0;
        cyc = 2;
        while (!done4 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ignore start lat", cyc, 4);
        check("ignore start prod", prod4, 8'h0F);
        tick();
        check("ignore start no rerun", busy4, 0);

        // Reset mid-calculation
        sm4 = 0; a4 = 4'hF; b4 = 4'hF; start4 = 1;
        tick();
        start4 = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("midrst busy", busy4, 0);
        check("midrst done", done4, 0);
        check("midrst prod", prod4, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done4) seen_done = 1'b1;
            tick();
        end
        check("midrst no done", seen_done, 0);
        run4("after rst 6*7", 0, 4'h6, 4'h7, 8'h2A);

        // WIDTH=8 sweep against integer arithmetic
        for (int n = 0; n < 1000; n++) begin
            sm8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (n == 0) begin a8 = 8'h80; b8 = 8'h80; sm8 = 1; end
            if (n == 1) begin a8 = 8'hFF; b8 = 8'hFF; sm8 = 0; end
            if (n == 2) begin a8 = 8'h80; b8 = 8'h7F; sm8 = 1; end
            sa = sm8 ? int'($signed(a8)) : int'(a8);
            sb = sm8 ? int'($signed(b8)) : int'(b8);
            exp16 = 16'(sa * sb);
            start8 = 1;
            tick();
            start8 = 0;
            cyc = 0;
            while (!done8 && cyc < 30) begin
                tick();
                cyc++;
            end
            total++;
            if (cyc != 8) begin
                bad++;
                $display("FAIL w8 lat op%0d: got=%0d expected=8", n, cyc);
            end
            total++;
            if (prod8 !== exp16) begin
                bad++;
                $display("FAIL w8 prod op%0d sm=%0d %0h*%0h: got=%0h expected=%0h",
                         n, sm8, a8, b8, prod8, exp16);
            end
        end
        $display("w8 sweep: 1000 ops checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
